sequence_generator_moore: RTL
=============================

// Module: sequence_generator_moore
// PURPOSE
//   Moore-style serial pattern transmitter: the drive end for the lab sequence detector.
//   Shifts a stored SEQ_LEN-bit pattern out MSB-first, one bit per clk, repeated (repeat_cnt+1) times back-to-back.
//   Handshake is start/busy/done. data_out/data_valid feed a detector's data_in directly or via a testbench.
// PARAMETERS
//   SEQ_LEN    4        pattern length in bits (2..16)
//   SEQ        4'b1010  reset value of the pattern register
//   REPEAT_W   3        width of repeat_cnt; max copies = 2**REPEAT_W
//   IDLE_LEVEL 1'b0     data_out level whenever data_valid=0
// PORTS
//   clk          in   1         clock, rising edge
//   reset        in   1         asynchronous, active-high
//   start        in   1         request a transmission (sampled in IDLE only)
//   load_pattern in   1         pattern_reg <= pattern_in (honoured in IDLE only)
//   pattern_in   in   SEQ_LEN   new pattern
//   repeat_cnt   in   REPEAT_W  extra copies to send, latched on accepted start
//   abort        in   1         terminate transmission
//   data_out     out  1         serial bit, registered
//   data_valid   out  1         1 while a pattern or parity bit is on data_out
//   busy         out  1         1 in SHIFT/PARITY
//   done         out  1         1-cycle pulse after the last bit of a completed run
//   state_out    out  3         current state code
// BEHAVIOUR
//   - Reset (async): state=IDLE, pattern_reg=SEQ, data_out=IDLE_LEVEL, data_valid=0, busy=0, done=0, state_out=0.
//   - States/codes: IDLE=0, SHIFT=1, PARITY=2, DONE=3. All outputs decode from registered state/shift_reg (Moore).
//   - IDLE: load_pattern=1 -> pattern_reg<=pattern_in.
//     start=1 -> shift_reg<=(load_pattern ? pattern_in : pattern_reg), rep<=repeat_cnt, bit_cnt<=0, ->SHIFT.
//     start+load_pattern same cycle: the new pattern is stored and sent.
//   - Latency: first bit appears on data_out the cycle after start is sampled.
//   - SHIFT: data_out=shift_reg[SEQ_LEN-1], data_valid=1, busy=1. Shift left and bit_cnt++ each clk.
//     On bit_cnt==SEQ_LEN-1 -> PARITY if enabled, else end-of-copy.
//   - End-of-copy: rep==0 -> DONE. Otherwise rep--, reload shift_reg from pattern_reg, stay SHIFT (no gap bit).
//   - DONE: done=1, data_valid=0, data_out=IDLE_LEVEL for exactly one cycle, then ->IDLE.
//   - Total valid cycles per run = (SEQ_LEN [+1 with parity]) * (repeat_cnt+1).
//   - start or load_pattern while busy: ignored. start held high re-triggers only after returning to IDLE.
//   - abort in SHIFT/PARITY: ->IDLE next clk. No done pulse; data_valid drops that clk.
//     abort with start in IDLE: abort wins, stay IDLE.
//   - repeat_cnt at all-ones: 2**REPEAT_W copies. bit_cnt is $clog2(SEQ_LEN) bits and wraps to 0 per copy.
//   - Reset mid-run: immediate return to reset values. pattern_reg also reverts to SEQ.
// CONFIGURATION
//   SEQ_GEN_PARITY_EN defined: after each copy, PARITY state emits one even-parity bit (^pattern_reg) with data_valid=1.
//   Undefined: PARITY state is unreachable, code 2 is never output, copies are SEQ_LEN bits.
// TESTING
//   1. Defaults, start pulse, repeat_cnt=0 -> data_out 1,0,1,0 over 4 valid cycles; done high in cycle 5; state_out 0,1,1,1,1,3,0.
//   2. load_pattern with pattern_in=4'b0110, then start with repeat_cnt=2 -> 12 valid bits 0110 0110 0110, no gaps, one done pulse.
//   3. start, then abort after 2 bits -> busy/data_valid low next clk, done never asserts, data_out=IDLE_LEVEL.
//   4. start re-asserted and load_pattern=4'b1111 mid-run -> run completes unchanged with 1010; pattern_reg still 1010 afterwards.
//   5. SEQ_GEN_PARITY_EN defined, pattern 4'b1011, repeat_cnt=1 -> 1,0,1,1,1,1,0,1,1,1; state 2 on bits 5 and 10.
//   6. Async reset asserted mid-SHIFT between clock edges -> all outputs at reset values immediately; next start sends SEQ.

Source files
------------

// File: rtl/sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// sequence_generator_moore
//   Moore-style serial pattern transmitter, the drive end for the lab
//   sequence detector. A stored SEQ_LEN-bit pattern is shifted out MSB-first,
//   one bit per clock, repeated (repeat_cnt+1) times back-to-back with no
//   gap bits between copies. Handshake is start / busy / done.
//
// Parameters
//   SEQ_LEN    pattern length in bits (2..16)
//   SEQ        reset value of the pattern register
//   REPEAT_W   width of repeat_cnt; max copies = 2**REPEAT_W
//   IDLE_LEVEL data_out level whenever data_valid = 0
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   request a transmission (sampled in IDLE only)
//   load_pattern in   pattern_reg <= pattern_in (honoured in IDLE only)
//   pattern_in   in   [SEQ_LEN-1:0] new pattern
//   repeat_cnt   in   [REPEAT_W-1:0] extra copies, latched on accepted start
//   abort        in   terminate transmission (wins over start in IDLE)
//   data_out     out  serial bit, decoded from registered state/shift_reg
//   data_valid   out  1 while a pattern or parity bit is on data_out
//   busy         out  1 in SHIFT/PARITY
//   done         out  1-cycle pulse after the last bit of a completed run
//   state_out    out  [2:0] state code: IDLE=0 SHIFT=1 PARITY=2 DONE=3
//
// Build option
//   SEQ_GEN_PARITY_EN : when defined, each copy is followed by one
//   even-parity bit (^pattern_reg) emitted from the PARITY state.
//   When undefined, PARITY is unreachable and copies are SEQ_LEN bits.
// -----------------------------------------------------------------------------
module sequence_generator_moore #(
  parameter int unsigned        SEQ_LEN    = 4,
  parameter logic [SEQ_LEN-1:0] SEQ        = 4'b1010,
  parameter int unsigned        REPEAT_W   = 3,
  parameter logic               IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                load_pattern,
  input  logic [SEQ_LEN-1:0]  pattern_in,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  input  logic                abort,
  output logic                data_out,
  output logic                data_valid,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_out
);

  localparam int unsigned        CNT_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_PARITY = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  state_t              r_state;
  logic [SEQ_LEN-1:0]  r_pattern;
  logic [SEQ_LEN-1:0]  r_shift;
  logic [REPEAT_W-1:0] r_rep;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nxt;
  logic [SEQ_LEN-1:0]  w_pattern_nxt;
  logic [SEQ_LEN-1:0]  w_shift_nxt;
  logic [REPEAT_W-1:0] w_rep_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_copy_end;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pattern <= SEQ;
      r_shift   <= '0;
      r_rep     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pattern_nxt;
      r_shift   <= w_shift_nxt;
      r_rep     <= w_rep_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_shift_nxt   = r_shift;
    w_rep_nxt     = r_rep;
    w_cnt_nxt     = r_cnt;
    w_copy_end    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (load_pattern) begin
          w_pattern_nxt = pattern_in;
        end
        if (start && !abort) begin
          // A same-cycle load is both stored and sent.
          w_shift_nxt = load_pattern ? pattern_in : r_pattern;
          w_rep_nxt   = repeat_cnt;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_shift_nxt = {r_shift[SEQ_LEN-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
`ifdef SEQ_GEN_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_copy_end  = 1'b1;
`endif
          end
        end
      end

`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_copy_end = 1'b1;
        end
      end
`endif

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // End of one copy: either finish, or reload the pattern and keep
    // shifting on the very next clock so copies are back-to-back.
    if (w_copy_end) begin
      if (r_rep == '0) begin
        w_state_nxt = S_DONE;
      end else begin
        w_rep_nxt   = r_rep - 1'b1;
        w_shift_nxt = r_pattern;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode (registers only, no input paths)
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out   = IDLE_LEVEL;
    data_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    state_out  = r_state;

    case (r_state)
      S_SHIFT: begin
        data_out   = r_shift[SEQ_LEN-1];
        data_valid = 1'b1;
        busy       = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        data_out   = ^r_pattern;
        data_valid = 1'b1;
        busy       = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        data_out = IDLE_LEVEL;
      end
    endcase
  end

endmodule
